// File: rtl/xilinx_pad_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : xilinx_pad_debounce
// Description : Input conditioner for slow board-level pads such as
//               push-buttons and slide switches. Each channel is first
//               synchronised into clk_i, then debounced by a per-channel
//               stability counter. Single-cycle rise and fall pulses mark
//               every change of the debounced level. All channels are
//               independent; only clock, reset and bypass are shared.
//
// Ports       : clk_i     in   1     system clock
//               rst_ni    in   1     asynchronous active-low reset
//               bypass_i  in   1     1 = level_o follows synchroniser output
//               pad_i     in   N_IN  raw asynchronous pad levels
//               level_o   out  N_IN  debounced level (registered)
//               rise_o    out  N_IN  1-cycle pulse on level_o 0->1
//               fall_o    out  N_IN  1-cycle pulse on level_o 1->0
//               busy_o    out  N_IN  stability counter non-zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module xilinx_pad_debounce #(
    parameter int              N_IN            = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter logic [N_IN-1:0] RESET_VALUE     = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            bypass_i,
    input  logic [N_IN-1:0] pad_i,
    output logic [N_IN-1:0] level_o,
    output logic [N_IN-1:0] rise_o,
    output logic [N_IN-1:0] fall_o,
    output logic [N_IN-1:0] busy_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Terminal count: the mismatch that reaches this value is the
    // DEBOUNCE_CYCLES-th consecutive one, so the level flips on it.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("xilinx_pad_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("xilinx_pad_debounce: SYNC_STAGES must be >= 2");
    end

    if (N_IN < 1) begin : g_bad_n_in
        $error("xilinx_pad_debounce: N_IN must be >= 1");
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_s;
        logic                   w_mismatch;
        logic                   w_at_last;
        logic                   w_flip;

        // Synchroniser: bit 0 samples the pad, the top bit is the only
        // version of the pad the rest of the channel ever looks at.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_sync <= {SYNC_STAGES{RESET_VALUE[i]}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i[i]};
            end
        end

        assign w_s        = r_sync[SYNC_STAGES-1];
        assign w_mismatch = w_s ^ r_level;
        assign w_at_last  = (r_cnt == c_cnt_last);
        // In bypass any mismatch is accepted immediately.
        assign w_flip     = w_mismatch & (bypass_i | w_at_last);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt   <= '0;
                r_level <= RESET_VALUE[i];
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= w_flip & w_s;
                r_fall <= w_flip & ~w_s;
                if (w_flip) begin
                    r_level <= w_s;
                end
                // Clearing at the terminal value keeps the counter from
                // ever wrapping; any matching cycle restarts the count.
                if (bypass_i || !w_mismatch || w_at_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign level_o[i] = r_level;
        assign rise_o[i]  = r_rise;
        assign fall_o[i]  = r_fall;
        assign busy_o[i]  = (r_cnt != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_xilinx_pad_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_xilinx_pad_debounce
// Description : Self-checking bench for xilinx_pad_debounce with N_IN=4,
//               SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RESET_VALUE=0. A
//               behavioural model (pad delay line plus run length of
//               disagreeing samples) is compared every cycle; a vector
//               table and directed sequences add fixed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xilinx_pad_debounce;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam logic [N-1:0] RV = '0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bypass;
    logic [N-1:0] pad;
    logic [N-1:0] level, rise, fall, busy;

    int n_tests = 0;
    int n_fail  = 0;

    xilinx_pad_debounce #(
        .N_IN           (N),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .RESET_VALUE    (RV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bypass_i(bypass),
        .pad_i   (pad),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [N-1:0] m_delay [SYNC];   // pad samples, [SYNC-1] is the synchronised view
    logic [N-1:0] m_level, m_rise, m_fall;
    int           m_run [N];        // consecutive cycles the synchronised pad disagreed

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_delay[k] = RV;
        m_level = RV;
        m_rise  = '0;
        m_fall  = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s;
        s = m_delay[SYNC-1];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] == m_level[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i] = bypass ? DB : m_run[i] + 1;
                if (m_run[i] >= DB) begin
                    m_level[i] = s[i];
                    m_rise[i]  = s[i];
                    m_fall[i]  = ~s[i];
                    m_run[i]   = 0;
                end
            end
        end
        for (int k = SYNC - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
        m_delay[0] = pad;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eb;
        for (int i = 0; i < N; i++) eb[i] = (m_run[i] != 0);
        check_vec({tag, ".level"}, level, m_level);
        check_vec({tag, ".rise"},  rise,  m_rise);
        check_vec({tag, ".fall"},  fall,  m_fall);
        check_vec({tag, ".busy"},  busy,  eb);
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
            check_model("in_reset");
        end
        rst_n = 1'b1;
    endtask

    // Cycles until level[idx] reaches val; -1 if it never does within maxc.
    task automatic wait_level(input int idx, input logic val, input int maxc,
                              input string tag, output int k);
        k = -1;
        for (int c = 1; c <= maxc; c++) begin
            step(tag);
            if (k < 0 && level[idx] === val) k = c;
        end
    endtask

    typedef struct {
        logic [N-1:0] pad;
        logic         byp;
        int           cycles;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] busy;
    } vec_t;

    vec_t tv [12];

    initial begin
        int k;
        int cnt;
        logic seen;
        logic r0;

        tv[0]  = '{4'b0000, 1'b0, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tv[1]  = '{4'b0001, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tv[2]  = '{4'b0001, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tv[3]  = '{4'b0001, 1'b0, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tv[4]  = '{4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tv[5]  = '{4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tv[6]  = '{4'b0000, 1'b1, 3, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tv[7]  = '{4'b0110, 1'b1, 3, 4'b0110, 4'b0110, 4'b0000, 4'b0000};
        tv[8]  = '{4'b0110, 1'b0, 2, 4'b0110, 4'b0000, 4'b0000, 4'b0000};
        tv[9]  = '{4'b0000, 1'b0, 5, 4'b0110, 4'b0000, 4'b0000, 4'b0110};
        tv[10] = '{4'b0000, 1'b1, 1, 4'b0000, 4'b0000, 4'b0110, 4'b0000};
        tv[11] = '{4'b0000, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        // 1: reset with a non-zero pad pattern
        pad = 4'b1010;
        bypass = 1'b0;
        hold_reset(3);
        check_vec("t1.level_rst", level, 4'b0000);
        for (int c = 0; c < 2; c++) begin
            step("t1.post");
            check_vec("t1.level_post", level, 4'b0000);
            check_vec("t1.busy_post",  busy,  4'b0000);
            check_vec("t1.pulse_post", rise | fall, 4'b0000);
        end

        // vector table
        pad = '0;
        hold_reset(2);
        foreach (tv[v]) begin
            pad    = tv[v].pad;
            bypass = tv[v].byp;
            repeat (tv[v].cycles) step("tbl.run");
            check_vec($sformatf("tbl%0d.level", v), level, tv[v].lvl);
            check_vec($sformatf("tbl%0d.rise",  v), rise,  tv[v].rise);
            check_vec($sformatf("tbl%0d.fall",  v), fall,  tv[v].fall);
            check_vec($sformatf("tbl%0d.busy",  v), busy,  tv[v].busy);
        end

        // 2: clean rising step on channel 0
        pad = '0;
        bypass = 1'b0;
        hold_reset(2);
        pad[0] = 1'b1;
        k = -1;
        for (int c = 1; c <= 14 && k < 0; c++) begin
            step("t2");
            if (level[0] === 1'b1) begin
                k = c;
                check_vec("t2.rise_first", rise & 4'b0001, 4'b0001);
            end
        end
        check_int("t2.latency", k, SYNC + DB);
        step("t2.after");
        check_vec("t2.rise_next", rise & 4'b0001, 4'b0000);

        // 3: channel 1 chatters every 3 cycles, then settles high
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) pad[1] = ~pad[1];
            step("t3.chatter");
            if (rise[1] === 1'b1 || level[1] !== 1'b0) seen = 1'b1;
        end
        check_vec("t3.no_change", {3'b000, seen}, 4'b0000);
        pad[1] = 1'b1;
        wait_level(1, 1'b1, 14, "t3.settle", k);
        check_int("t3.latency", k, SYNC + DB);

        // 4: 7-cycle glitch on channel 2 never reaches the level
        cnt  = 0;
        seen = 1'b0;
        pad[2] = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c == 7) pad[2] = 1'b0;
            step("t4");
            if (busy[2] === 1'b1) cnt++;
            if (level[2] !== 1'b0) seen = 1'b1;
        end
        check_int("t4.busy_cycles", cnt, 7);
        check_vec("t4.level_held", {3'b000, seen}, 4'b0000);

        // 5: simultaneous fall on ch3 and rise on ch0
        pad = 4'b1000;
        repeat (14) step("t5.prep");
        check_vec("t5.prep_level", level, 4'b1000);
        pad = 4'b0001;
        k  = -1;
        r0 = 1'b0;
        for (int c = 1; c <= 14 && k < 0; c++) begin
            step("t5");
            if (fall[3] === 1'b1) begin
                k  = c;
                r0 = rise[0];
            end
        end
        check_int("t5.fall3_latency", k, SYNC + DB);
        check_vec("t5.rise0_same_cycle", {3'b000, r0}, 4'b0001);

        // 6: reset mid-count, then full latency again; bypass repeat
        pad = '0;
        repeat (14) step("t6.prep");
        pad[0] = 1'b1;
        repeat (SYNC + 5) step("t6.count");
        check_vec("t6.busy_mid", busy & 4'b0001, 4'b0001);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_vec("t6.async_busy",  busy,  4'b0000);
        check_vec("t6.async_level", level, 4'b0000);
        hold_reset(2);
        wait_level(0, 1'b1, 14, "t6.relatch", k);
        check_int("t6.latency", k, SYNC + DB);
        bypass = 1'b1;
        hold_reset(2);
        // level registers the synchronised pad, so one flop follows the chain
        wait_level(0, 1'b1, 6, "t6.bypass", k);
        check_int("t6.bypass_latency", k, SYNC + 1);

        // randomized phase against the model
        bypass = 1'b0;
        pad = '0;
        hold_reset(2);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(11) == 0) pad[i] = ~pad[i];
            if ($urandom_range(63) == 0) bypass = ~bypass;
            if (c == 1500) hold_reset(2);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
